// File: rtl/mips_program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_program_loader_pkg
//  Description : Shared types and constants for the MIPS program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_program_loader_pkg;

    localparam int HEADER_BYTES   = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_COUNT_W   = 16;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/mips_program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_program_loader_if
//  Description : Byte-stream input and program-memory write port bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_program_loader_if;

    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;

    // Loader side: consumes bytes, drives the memory write port.
    modport master (
        input  byte_valid_i,
        input  byte_data_i,
        output byte_ready_o,
        output wr_en_o,
        output wr_addr_o,
        output wr_data_o
    );

    // Environment side: byte source and memory.
    modport slave (
        output byte_valid_i,
        output byte_data_i,
        input  byte_ready_o,
        input  wr_en_o,
        input  wr_addr_o,
        input  wr_data_o
    );

endinterface
`default_nettype wire

// File: rtl/loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : loader_word_assembler
//  Description : Packs big-endian bytes into 32-bit words; flags the byte
//                that completes a word.
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_word_assembler
    import mips_program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [23:0]      shift_q;
    logic [IDX_W-1:0] idx_q;

    // The completing byte is appended combinationally so the top can
    // register the full word in the same edge that accepts it.
    assign word_o       = {shift_q, byte_i};
    assign word_ready_o = accept_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    // Shift register and byte index; the index wraps naturally every word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (clear_i) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (accept_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            idx_q   <= idx_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mips_program_loader
//  Description : Receives a length-prefixed, checksummed byte image, writes it
//                into program memory and releases the CPU once verified.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_program_loader
    import mips_program_loader_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_program_loader_if.master   bus,
    input  logic                    start_i,
    output logic                    cpu_reset_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [WORD_COUNT_W-1:0] words_loaded_o
);

    loader_state_e           state_q, state_d;
    logic [WORD_COUNT_W-1:0] len_q, len_d;
    logic [WORD_COUNT_W-1:0] words_q, words_d;
    logic [7:0]              csum_q, csum_d;
    logic                    wr_en_q, wr_en_d;
    logic [31:0]             wr_addr_q, wr_addr_d;
    logic [31:0]             wr_data_q, wr_data_d;
    logic                    byte_ready_q, byte_ready_d;
    logic                    cpu_reset_q, cpu_reset_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    w_accept;
    logic                    w_asm_clear;
    logic [31:0]             w_word;
    logic                    w_word_ready;
    logic [WORD_COUNT_W-1:0] w_len;

    assign w_accept = bus.byte_valid_i && byte_ready_q;
    assign w_len    = {len_q[15:8], bus.byte_data_i};

    loader_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (w_asm_clear),
        .accept_i     (w_accept && (state_q == DATA)),
        .byte_i       (bus.byte_data_i),
        .word_o       (w_word),
        .word_ready_o (w_word_ready)
    );

    // Next-state, checksum, write-port and status decode.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        words_d     = words_q;
        csum_d      = csum_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        w_asm_clear = 1'b0;

        case (state_q)
            LEN_HI: if (w_accept) begin
                len_d   = {bus.byte_data_i, len_q[7:0]};
                csum_d  = csum_q ^ bus.byte_data_i;
                state_d = LEN_LO;
            end
            LEN_LO: if (w_accept) begin
                len_d  = w_len;
                csum_d = csum_q ^ bus.byte_data_i;
                if ((w_len == '0) || ({16'd0, w_len} > 32'(MEMORY_DEPTH)))
                    state_d = ERROR;
                else
                    state_d = DATA;
            end
            DATA: if (w_accept) begin
                csum_d = csum_q ^ bus.byte_data_i;
                if (w_word_ready) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = BASE_ADDR + {14'd0, words_q, 2'b00};
                    wr_data_d = w_word;
                    words_d   = words_q + 1'b1;
                    if (words_q == len_q - 1'b1)
                        state_d = CHECK;
                end
            end
            CHECK: if (w_accept) begin
                state_d = (bus.byte_data_i == csum_q) ? DONE : ERROR;
            end
            DONE, ERROR: if (start_i) begin
                state_d     = LEN_HI;
                len_d       = '0;
                words_d     = '0;
                csum_d      = '0;
                w_asm_clear = 1'b1;
            end
            default: state_d = LEN_HI;
        endcase

        // Status outputs are registered images of the upcoming state.
        byte_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                       (state_d == DATA)   || (state_d == CHECK);
        cpu_reset_d  = (state_d != DONE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERROR);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LEN_HI;
            len_q        <= '0;
            words_q      <= '0;
            csum_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            wr_data_q    <= '0;
            byte_ready_q <= 1'b1;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            words_q      <= words_d;
            csum_q       <= csum_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            byte_ready_q <= byte_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.byte_ready_o = byte_ready_q;
    assign bus.wr_en_o      = wr_en_q;
    assign bus.wr_addr_o    = wr_addr_q;
    assign bus.wr_data_o    = wr_data_q;
    assign cpu_reset_o      = cpu_reset_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign words_loaded_o   = words_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_program_loader
//  Description : Directed self-checking bench for mips_program_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_program_loader;

    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] cnt;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        cpu_reset, done, error;
    logic [15:0] words_loaded;

    int n_vec = 0;
    int n_err = 0;

    wr_t  exp_q[$];
    logic exp_done, exp_error;
    int   exp_words;

    mips_program_loader_if bus ();

    mips_program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.master),
        .start_i        (start),
        .cpu_reset_o    (cpu_reset),
        .done_o         (done),
        .error_o        (error),
        .words_loaded_o (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: derives expected writes and final status from the
    // stream format alone.
    task automatic model(input logic [7:0] s[$]);
        int         n;
        logic [7:0] csum;
        wr_t        w;
        n         = {s[0], s[1]};
        exp_done  = 1'b0;
        exp_error = 1'b0;
        exp_words = 0;
        if (n == 0 || n > DEPTH) begin
            exp_error = 1'b1;
        end else begin
            csum = 8'h00;
            for (int i = 0; i < 2 + 4 * n; i++) csum ^= s[i];
            for (int k = 0; k < n; k++) begin
                w.addr = BASE + 32'(4 * k);
                w.data = {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]};
                w.cnt  = 16'(k + 1);
                exp_q.push_back(w);
            end
            exp_words = n;
            if (s[2 + 4 * n] == csum) exp_done = 1'b1;
            else                      exp_error = 1'b1;
        end
    endtask

    // Every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (bus.wr_en_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                check("wr_addr", bus.wr_addr_o, exp_q[0].addr);
                check("wr_data", bus.wr_data_o, exp_q[0].data);
                check("words_at_write", {16'd0, words_loaded}, {16'd0, exp_q[0].cnt});
                void'(exp_q.pop_front());
            end
        end
    end

    // Offers each byte until accepted; maxgap inserts idle cycles first.
    task automatic send(input logic [7:0] s[$], input int maxgap);
        int gap;
        int t;
        bit acc;
        for (int i = 0; i < s.size(); i++) begin
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gap) begin
                bus.byte_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            bus.byte_valid_i = 1'b1;
            bus.byte_data_i  = s[i];
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 20) begin
                acc = bus.byte_ready_o;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) check("accept_timeout", 32'd0, 32'd1);
        end
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic check_final();
        repeat (2) @(posedge clk);
        #1;
        check("done",         {31'd0, done},         {31'd0, exp_done});
        check("error",        {31'd0, error},        {31'd0, exp_error});
        check("cpu_reset",    {31'd0, cpu_reset},    {31'd0, ~exp_done});
        check("byte_ready",   {31'd0, bus.byte_ready_o}, 32'd0);
        check("words_loaded", {16'd0, words_loaded}, 32'(exp_words));
        check("writes_missing", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_image(input logic [7:0] s[$], input int maxgap);
        model(s);
        send(s, maxgap);
        check_final();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_cpu_reset",  {31'd0, cpu_reset},       32'd1);
        check("start_done",       {31'd0, done},            32'd0);
        check("start_error",      {31'd0, error},           32'd0);
        check("start_ready",      {31'd0, bus.byte_ready_o}, 32'd1);
        check("start_words",      {16'd0, words_loaded},    32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},     {31'd0, bus.byte_ready_o}, 32'd1);
        check({tag, "_wr_en"},     {31'd0, bus.wr_en_o},      32'd0);
        check({tag, "_wr_addr"},   bus.wr_addr_o,             BASE);
        check({tag, "_wr_data"},   bus.wr_data_o,             32'd0);
        check({tag, "_cpu_reset"}, {31'd0, cpu_reset},        32'd1);
        check({tag, "_done"},      {31'd0, done},             32'd0);
        check({tag, "_error"},     {31'd0, error},            32'd0);
        check({tag, "_words"},     {16'd0, words_loaded},     32'd0);
    endtask

    logic [7:0] img1[$]    = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                               8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02};
    logic [7:0] img1bad[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                               8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h03};
    logic [7:0] hdr0[$]    = '{8'h00, 8'h00};
    logic [7:0] hdr33[$]   = '{8'h00, 8'h21};
    logic [7:0] partial[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    logic [7:0] img3[$]    = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};

    initial begin
        wr_t w;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
        #1 reset = 1'b1;
        #3 check_reset_values("por");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Pin the model against hand-derived values for the first image.
        model(img1);
        check("model_done", {31'd0, exp_done}, 32'd1);
        check("model_w0",   exp_q[0].data,     32'h1234_5678);
        check("model_a1",   exp_q[1].addr,     32'h0000_0004);
        check("model_w1",   exp_q[1].data,     32'h9ABC_DEF0);
        exp_q.delete();

        // Valid image, back-to-back bytes.
        run_image(img1, 0);
        check("img1_done_lit",  {31'd0, done},         32'd1);
        check("img1_words_lit", {16'd0, words_loaded}, 32'd2);

        // Bad checksum.
        pulse_start();
        run_image(img1bad, 0);
        check("bad_error_lit", {31'd0, error}, 32'd1);

        // Header rejections.
        pulse_start();
        run_image(hdr0, 0);
        pulse_start();
        run_image(hdr33, 0);
        check("hdr33_error_lit", {31'd0, error}, 32'd1);

        // Valid image with random source gaps.
        pulse_start();
        run_image(img1, 5);

        // Reset mid-load after 5 payload bytes (first word already written).
        pulse_start();
        w.addr = BASE; w.data = 32'h1234_5678; w.cnt = 16'd1;
        exp_q.push_back(w);
        send(partial, 0);
        reset = 1'b1;
        #3 check_reset_values("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_writes", 32'(exp_q.size()), 32'd0);
        run_image(img1, 0);

        // Restart from DONE with a one-word image.
        pulse_start();
        run_image(img3, 0);
        check("img3_done_lit",  {31'd0, done},         32'd1);
        check("img3_words_lit", {16'd0, words_loaded}, 32'd1);
        check("img3_wdata_lit", bus.wr_data_o,         32'hAABB_CCDD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mips_program_loader.md
Name: mips_program_loader

Overview:
- Writer-side counterpart to the processor's instruction fetch path. It receives a byte stream, assembles big-endian 32-bit instruction words, and writes them sequentially into program memory.
- Holds the processor in reset while loading and releases it only after a complete, checksum-verified image has been written.
- Sits between a byte source (UART receiver or testbench) and the program memory write port.

Parameters:
- MEMORY_DEPTH, 32, program memory capacity in words; larger images are rejected.
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- byte_valid_i  input  1  byte_data_i holds a valid byte.
- byte_data_i  input  8  incoming stream byte.
- byte_ready_o  output  1  loader can accept a byte; transfer occurs when valid and ready are both high on a clk edge.
- start_i  input  1  one-cycle pulse that restarts loading from DONE or ERROR.
- wr_en_o  output  1  program memory write strobe, one cycle per word.
- wr_addr_o  output  32  word-aligned byte address.
- wr_data_o  output  32  instruction word.
- cpu_reset_o  output  1  processor reset; high while loading or in error.
- done_o  output  1  image loaded and verified.
- error_o  output  1  image rejected.
- words_loaded_o  output  16  count of words written in the current load.

Behaviour:
- Reset values: state LEN_HI; byte_ready_o 1; wr_en_o 0; wr_addr_o BASE_ADDR; wr_data_o 0; cpu_reset_o 1; done_o 0; error_o 0; words_loaded_o 0. The checksum, byte index and length registers are also cleared.
- Stream format, in order:
  - 2-byte word count N, big-endian.
  - N*4 payload bytes, most significant byte first per word.
  - 1 checksum byte equal to the XOR of all preceding bytes, header included.
- States:
  - LEN_HI: on accept, store N[15:8] and go to LEN_LO.
  - LEN_LO: on accept, store N[7:0]. If N==0 or N>MEMORY_DEPTH go to ERROR, otherwise go to DATA.
  - DATA: on each accept, shift the byte into the word and increment the byte index (2 bits). The 4th byte completes a word. After the write of word N-1 is issued, go to CHECK.
  - CHECK: on accept, compare the running XOR with the received byte. Equal goes to DONE; unequal goes to ERROR.
  - DONE / ERROR: byte_ready_o 0. A start_i pulse clears all counters, the checksum, done_o, error_o and words_loaded_o, re-asserts cpu_reset_o and returns to LEN_HI.
- byte_ready_o is 1 in LEN_HI, LEN_LO, DATA and CHECK. The loader never stalls mid-image.
- Write timing: wr_en_o pulses high for exactly the one cycle after the 4th byte of a word is accepted. wr_addr_o = BASE_ADDR + 4*index and wr_data_o hold the assembled word during that cycle and remain stable afterwards. words_loaded_o increments in the same cycle.
- Back-to-back bytes (valid held high) are accepted every cycle. Consecutive writes are therefore spaced at least 4 cycles apart.
- All outputs are registered. cpu_reset_o is 0 only in DONE and falls in the same cycle done_o rises, i.e. the cycle after the checksum byte is accepted. error_o is high only in ERROR, where cpu_reset_o stays 1.
- start_i is ignored outside DONE and ERROR.
- reset asserted mid-load aborts immediately to reset values. Partially written memory is not cleared.
- Address arithmetic is 32-bit with no wrap check beyond the MEMORY_DEPTH limit on N.

Decomposition:
- Shared package holds:
  - the state encoding enum (LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR);
  - HEADER_BYTES=2 and BYTES_PER_WORD=4;
  - the word-count width of 16.
- One natural sub-module, loader_word_assembler: a shift register plus 2-bit byte index, emitting a word_ready pulse. The FSM, checksum and address counter stay in the top.

Test Plan:
- Bytes 00 02, 12 34 56 78, 9A BC DE F0, checksum 02, valid held high. Expect:
  - wr_en_o pulses with addr 0x0 / data 0x12345678, then addr 0x4 / data 0x9ABCDEF0;
  - done_o=1, cpu_reset_o=0, words_loaded_o=2.
- Same image with checksum 03. Expect both writes, then error_o=1, cpu_reset_o=1, done_o=0, byte_ready_o=0.
- Header 00 00, or header 00 21 with MEMORY_DEPTH=32. Expect ERROR after the 2nd byte and no wr_en_o.
- First image with byte_valid_i toggling randomly (gaps of 0–5 cycles). Expect identical writes and addresses, and no byte lost or duplicated.
- Assert reset after 5 payload bytes, release, then send the full first image. Expect writes to start again at addr 0x0 with correct data and done_o=1.
- From DONE, pulse start_i and send the 1-word image 00 01, AA BB CC DD, checksum 01. Expect:
  - cpu_reset_o re-asserts the cycle after start_i;
  - write addr 0x0 data 0xAABBCCDD;
  - done_o=1 with words_loaded_o=1.
